// File: rtl/axi4lite_master.sv
// Single-outstanding AXI4-Lite initiator: accepted command drives the bus one cycle later, response held until rsp_ready.
// Slave stalls on any channel hold the current state indefinitely; cmd_ready is high only in IDLE.
module axi4lite_master #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic              clk,
   input  logic              reset_n,

   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [AW-1:0]     cmd_addr,
   input  logic [DW-1:0]     cmd_wdata,
   input  logic [DW/8-1:0]   cmd_wstrb,

   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_write,
   output logic [DW-1:0]     rsp_rdata,
   output logic [1:0]        rsp_resp,
   output logic              busy,

   output logic              awvalid,
   input  logic              awready,
   output logic [AW-1:0]     awaddr,

   output logic              wvalid,
   input  logic              wready,
   output logic [DW-1:0]     wdata,
   output logic [DW/8-1:0]   wstrb,

   input  logic              bvalid,
   output logic              bready,
   input  logic [1:0]        bresp,

   output logic              arvalid,
   input  logic              arready,
   output logic [AW-1:0]     araddr,

   input  logic              rvalid,
   output logic              rready,
   input  logic [DW-1:0]     rdata,
   input  logic [1:0]        rresp
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR      = 3'd1,
      WR_RESP = 3'd2,
      RD_ADDR = 3'd3,
      RD_DATA = 3'd4,
      DONE    = 3'd5
   } state_t;

   localparam logic [AW-1:0] ALIGN_MASK = ~AW'(3);

   state_t          state;
   logic [AW-1:0]   aligned_addr;
   logic            aw_done;
   logic            w_done;

   assign cmd_ready    = (state == IDLE);
   assign busy         = (state != IDLE);
   assign aligned_addr = cmd_addr & ALIGN_MASK;

   // A channel counts as done if it already completed or completes on this edge.
   assign aw_done = !awvalid || awready;
   assign w_done  = !wvalid  || wready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         awvalid   <= 1'b0;
         awaddr    <= '0;
         wvalid    <= 1'b0;
         wdata     <= '0;
         wstrb     <= '0;
         bready    <= 1'b0;
         arvalid   <= 1'b0;
         araddr    <= '0;
         rready    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_write <= 1'b0;
         rsp_rdata <= '0;
         rsp_resp  <= 2'b00;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  if (cmd_write) begin
                     awaddr  <= aligned_addr;
                     wdata   <= cmd_wdata;
                     wstrb   <= cmd_wstrb;
                     awvalid <= 1'b1;
                     wvalid  <= 1'b1;
                     state   <= WR;
                  end else begin
                     araddr  <= aligned_addr;
                     arvalid <= 1'b1;
                     state   <= RD_ADDR;
                  end
               end
            end

            WR: begin
               if (awvalid && awready) begin
                  awvalid <= 1'b0;
               end
               if (wvalid && wready) begin
                  wvalid <= 1'b0;
               end
               if (aw_done && w_done) begin
                  bready <= 1'b1;
                  state  <= WR_RESP;
               end
            end

            WR_RESP: begin
               if (bvalid) begin
                  bready    <= 1'b0;
                  rsp_resp  <= bresp;
                  rsp_rdata <= '0;
                  rsp_write <= 1'b1;
                  rsp_valid <= 1'b1;
                  state     <= DONE;
               end
            end

            RD_ADDR: begin
               if (arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  state   <= RD_DATA;
               end
            end

            RD_DATA: begin
               if (rvalid) begin
                  rready    <= 1'b0;
                  rsp_rdata <= rdata;
                  rsp_resp  <= rresp;
                  rsp_write <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= DONE;
               end
            end

            DONE: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi4lite_master.sv
// Directed bench for axi4lite_master with a 16-word register slave model that can stall AW and return read errors.
`timescale 1ns/1ps
module tb_axi4lite_master;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk;
   logic          reset_n;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [31:0]   cmd_wdata;
   logic [3:0]    cmd_wstrb;
   logic          rsp_valid, rsp_ready, rsp_write;
   logic [31:0]   rsp_rdata;
   logic [1:0]    rsp_resp;
   logic          busy;
   logic          awvalid, awready;
   logic [AW-1:0] awaddr;
   logic          wvalid, wready;
   logic [31:0]   wdata;
   logic [3:0]    wstrb;
   logic          bvalid, bready;
   logic [1:0]    bresp;
   logic          arvalid, arready;
   logic [AW-1:0] araddr;
   logic          rvalid, rready;
   logic [31:0]   rdata;
   logic [1:0]    rresp;

   axi4lite_master #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- slave model ----------------
   logic              s_rst_n;
   logic [15:0][31:0] mem;
   int                s_aw_stall;
   bit                s_err;
   logic              s_aw_got, s_w_got;
   logic [31:0]       s_aw_addr, s_wdata;
   logic [3:0]        s_wstrb;
   int                s_aw_wait;

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] strb);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   always @(posedge clk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         awready <= 0; wready <= 0; bvalid <= 0; bresp <= 0;
         arready <= 0; rvalid <= 0; rdata <= 0; rresp <= 0;
         s_aw_got <= 0; s_w_got <= 0; s_aw_addr <= 0; s_wdata <= 0; s_wstrb <= 0;
         s_aw_wait <= 0; mem <= '0;
      end else begin
         if (awvalid && awready) begin
            awready <= 0; s_aw_got <= 1; s_aw_addr <= awaddr; s_aw_wait <= 0;
         end else if (awvalid && !s_aw_got) begin
            if (s_aw_wait >= s_aw_stall) awready <= 1;
            else s_aw_wait <= s_aw_wait + 1;
         end
         if (wvalid && wready) begin
            wready <= 0; s_w_got <= 1; s_wdata <= wdata; s_wstrb <= wstrb;
         end else if (wvalid && !s_w_got) begin
            wready <= 1;
         end
         if (bvalid && bready) begin
            bvalid <= 0; s_aw_got <= 0; s_w_got <= 0;
         end else if (s_aw_got && s_w_got && !bvalid) begin
            mem[s_aw_addr[5:2]] <= merge(mem[s_aw_addr[5:2]], s_wdata, s_wstrb);
            bvalid <= 1; bresp <= 2'b00;
         end
         if (arvalid && arready) begin
            arready <= 0; rvalid <= 1;
            rdata   <= s_err ? 32'h1234_5678 : mem[araddr[5:2]];
            rresp   <= s_err ? 2'b10 : 2'b00;
         end else if (arvalid && !arready && !rvalid) begin
            arready <= 1;
         end
         if (rvalid && rready) rvalid <= 0;
      end
   end

   // ---------------- protocol monitor ----------------
   int          mon_bad = 0;
   logic        prev_awvalid, prev_wvalid;
   logic [31:0] prev_awaddr, prev_wdata;

   always @(negedge clk) begin
      if (reset_n) begin
         if (bready && !(s_aw_got && s_w_got)) mon_bad++;
         if (awvalid && prev_awvalid && awaddr != prev_awaddr) mon_bad++;
         if (wvalid && prev_wvalid && wdata != prev_wdata) mon_bad++;
         if (cmd_ready && (awvalid || wvalid || bready || arvalid || rready || rsp_valid)) mon_bad++;
      end
      prev_awvalid = awvalid; prev_awaddr = awaddr;
      prev_wvalid  = wvalid;  prev_wdata  = wdata;
   end

   // ---------------- checking ----------------
   int checks = 0;
   int errors = 0;
   int cur    = -1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL v%0d %s: got 0x%0h expected 0x%0h", cur, name, act, exp);
      end
   endtask

   typedef struct packed {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] exp_addr;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_resp;
      bit          err;
      int          aw_stall;
      int          hold;
      int          exp_lat;
      int          exp_aw_clr;
      int          exp_w_clr;
      int          exp_b_rise;
   } vec_t;

   vec_t vecs [11];

   task automatic run_vec(input vec_t v);
      int lat, aw_clr, w_clr, b_rise, n, bad;
      logic [31:0] h_rdata;
      logic [1:0]  h_resp;
      logic        h_write;
      s_aw_stall = v.aw_stall;
      s_err      = v.err;
      cmd_valid  = 1; cmd_write = v.wr; cmd_addr = v.addr;
      cmd_wdata  = v.wdata; cmd_wstrb = v.strb;
      n = 0;
      while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
      check("cmd_accept", cmd_ready, 1);
      if (!cmd_ready) begin cmd_valid = 0; return; end
      @(negedge clk);
      cmd_valid = 0;
      check("first_valids", {awvalid, wvalid, arvalid, busy, cmd_ready},
            v.wr ? 5'b11010 : 5'b00110);
      check("bus_addr", v.wr ? awaddr : araddr, v.exp_addr);
      if (v.wr) check("wdata_wstrb", {wdata, wstrb}, {v.wdata, v.strb});
      lat = 0; aw_clr = -1; w_clr = -1; b_rise = -1;
      while (!rsp_valid && lat < 200) begin
         if (aw_clr < 0 && !awvalid) aw_clr = lat;
         if (w_clr  < 0 && !wvalid)  w_clr  = lat;
         if (b_rise < 0 && bready)   b_rise = lat;
         @(negedge clk);
         lat++;
      end
      check("rsp_latency", lat, v.exp_lat);
      if (!rsp_valid) return;
      check("rsp_write", rsp_write, v.wr);
      check("rsp_rdata", rsp_rdata, v.exp_rdata);
      check("rsp_resp", rsp_resp, v.exp_resp);
      if (v.wr) begin
         check("aw_clear_cycle", aw_clr, v.exp_aw_clr);
         check("w_clear_cycle", w_clr, v.exp_w_clr);
         check("bready_cycle", b_rise, v.exp_b_rise);
      end
      h_rdata = rsp_rdata; h_resp = rsp_resp; h_write = rsp_write;
      bad = 0;
      for (int i = 0; i < v.hold; i++) begin
         @(negedge clk);
         if (!rsp_valid || cmd_ready || rsp_rdata != h_rdata || rsp_resp != h_resp
             || rsp_write != h_write) bad++;
      end
      if (v.hold > 0) check("rsp_hold", bad, 0);
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
      check("idle_after", {rsp_valid, cmd_ready, busy}, 3'b010);
   endtask

   bit          b2b_wr    [4];
   logic [31:0] b2b_addr  [4];
   logic [31:0] b2b_data  [4];
   logic [31:0] b2b_exp   [4];

   initial begin
      vec_t fresh;
      int issued, got;
      //             wr  addr          wdata          strb   exp_addr      exp_rdata      rsp    err stall hold lat awc wc  br
      vecs[0]  = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 32'h0000_0008, 32'h0000_0000, 2'b00, 1'b0, 0, 0,  4, 2, 2, 2};
      vecs[1]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 32'h0000_0008, 32'hDEAD_BEEF, 2'b00, 1'b0, 0, 0,  3, 0, 0, 0};
      vecs[2]  = '{1'b1, 32'h0000_0008, 32'h0000_AB00, 4'h2, 32'h0000_0008, 32'h0000_0000, 2'b00, 1'b0, 0, 0,  4, 2, 2, 2};
      vecs[3]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 32'h0000_0008, 32'hDEAD_ABEF, 2'b00, 1'b0, 0, 0,  3, 0, 0, 0};
      vecs[4]  = '{1'b1, 32'h0000_0007, 32'h1122_3344, 4'hF, 32'h0000_0004, 32'h0000_0000, 2'b00, 1'b0, 0, 0,  4, 2, 2, 2};
      vecs[5]  = '{1'b0, 32'h0000_0007, 32'h0,         4'h0, 32'h0000_0004, 32'h1122_3344, 2'b00, 1'b0, 0, 0,  3, 0, 0, 0};
      vecs[6]  = '{1'b1, 32'h0000_000C, 32'hCAFE_F00D, 4'hF, 32'h0000_000C, 32'h0000_0000, 2'b00, 1'b0, 5, 0,  9, 7, 2, 7};
      vecs[7]  = '{1'b0, 32'h0000_000C, 32'h0,         4'h0, 32'h0000_000C, 32'hCAFE_F00D, 2'b00, 1'b0, 0, 10, 3, 0, 0, 0};
      vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0000_0000, 32'h1234_5678, 2'b10, 1'b1, 0, 0,  3, 0, 0, 0};
      vecs[9]  = '{1'b1, 32'h0000_003C, 32'h0BAD_C0DE, 4'hC, 32'h0000_003C, 32'h0000_0000, 2'b00, 1'b0, 0, 0,  4, 2, 2, 2};
      vecs[10] = '{1'b0, 32'h0000_003C, 32'h0,         4'h0, 32'h0000_003C, 32'h0BAD_0000, 2'b00, 1'b0, 0, 0,  3, 0, 0, 0};

      b2b_wr   = '{1'b1, 1'b0, 1'b1, 1'b0};
      b2b_addr = '{32'h10, 32'h10, 32'h14, 32'h14};
      b2b_data = '{32'hA5A5_0001, 32'h0, 32'h5A5A_0002, 32'h0};
      b2b_exp  = '{32'h0, 32'hA5A5_0001, 32'h0, 32'h5A5A_0002};

      reset_n = 1; s_rst_n = 1;
      cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
      rsp_ready = 0; s_aw_stall = 0; s_err = 0;
      #2;
      reset_n = 0; s_rst_n = 0;
      repeat (3) @(negedge clk);
      check("reset_ctrl", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_write,
                           cmd_ready, busy}, 9'b000000010);
      check("reset_rsp", {rsp_rdata, rsp_resp}, 34'h0);
      check("reset_addr", {awaddr, araddr}, 64'h0);
      check("reset_wdata", {wdata, wstrb}, 36'h0);
      reset_n = 1; s_rst_n = 1;
      @(negedge clk);

      for (int i = 0; i < 11; i++) begin
         cur = i;
         run_vec(vecs[i]);
         @(negedge clk);
      end

      // reset asserted while the read address is on the bus
      cur = 100;
      s_aw_stall = 0; s_err = 0;
      cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h8;
      @(negedge clk);
      cmd_valid = 0;
      check("midrd_arvalid", arvalid, 1);
      reset_n = 0;
      #1;
      check("midrd_reset_outs", {arvalid, rready, rsp_valid, cmd_ready, busy}, 5'b00010);
      @(negedge clk);
      reset_n = 1;
      @(negedge clk);
      check("midrd_after_release", {cmd_ready, arvalid, rsp_valid}, 3'b100);
      fresh = vecs[3];
      cur = 101;
      run_vec(fresh);

      // back-to-back with cmd_valid held high
      cur = 200;
      issued = 0; got = 0; rsp_ready = 1;
      @(negedge clk);
      for (int c = 0; c < 100; c++) begin
         if (rsp_valid) begin
            if (got < 4) begin
               check("b2b_write", rsp_write, b2b_wr[got]);
               check("b2b_rdata", rsp_rdata, b2b_exp[got]);
            end
            got++;
         end
         if (issued < 4) begin
            cmd_valid = 1; cmd_write = b2b_wr[issued];
            cmd_addr = b2b_addr[issued]; cmd_wdata = b2b_data[issued]; cmd_wstrb = 4'hF;
         end else begin
            cmd_valid = 0;
         end
         if (cmd_valid && cmd_ready) issued++;
         @(negedge clk);
      end
      rsp_ready = 0; cmd_valid = 0;
      check("b2b_count", got, 4);

      cur = -1;
      check("protocol_monitor", mon_bad, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
